seq_bit_serializer: RTL and testbench

Parallel-to-serial stage that feeds the serial bit input (`x`) of the overlapping Mealy sequence detectors in the FSM group. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts words out one bit per clock, back-to-back with no gaps. When no data is pending, the serial line idles at 0, so the downstream detector sees a clean stream.

---
 rtl/seq_pkg.sv | 17 +
 rtl/ser_shift_reg.sv | 61 ++++++
 rtl/seq_bit_serializer.sv | 103 ++++++++++
 tb/tb_seq_bit_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_pkg : shared types and constants for the sequence-detector group  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seq_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Level driven on the serial line when no data bit is present.
  localparam logic IDLE_LEVEL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ser_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_shift_reg : loadable shift register with bits-remaining counter   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_bit,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_next;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit = sh_q[WIDTH-1];
      assign sh_next = {sh_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit = sh_q[0];
      assign sh_next = {1'b0, sh_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = load_data;
      cnt_d = C_CNT_MAX;
    end else if (shift) begin
      sh_d  = sh_next;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_bit_serializer : valid/ready word in, gap-free serial bits out    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] hd_q, hd_d;
  logic             hd_valid_q, hd_valid_d;

  logic             sh_load, sh_shift;
  logic [WIDTH-1:0] sh_load_data;
  logic             sh_bit;
  logic [CNT_W-1:0] cnt;
  logic             shifter_free, xfer;

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_shift (
    .clk       (clk),
    .clear     (clear),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (sh_load_data),
    .out_bit   (sh_bit),
    .cnt       (cnt)
  );

  assign in_ready     = !hd_valid_q;
  assign xfer         = in_valid && in_ready;
  // Free when idle or the last bit of the current word is on the line.
  assign shifter_free = (state_q == IDLE) || (cnt == '0);

  always_comb begin
    state_d      = state_q;
    hd_d         = hd_q;
    hd_valid_d   = hd_valid_q;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_load_data = hd_q;
    if (shifter_free && hd_valid_q) begin
      sh_load      = 1'b1;
      sh_load_data = hd_q;
      hd_valid_d   = 1'b0;
      state_d      = SHIFT;
      if (xfer) begin
        hd_d       = in_data;
        hd_valid_d = 1'b1;
      end
    end else if (shifter_free && xfer) begin
      sh_load      = 1'b1;
      sh_load_data = in_data;
      state_d      = SHIFT;
    end else if (shifter_free) begin
      state_d = IDLE;
    end else begin
      sh_shift = 1'b1;
      if (xfer) begin
        hd_d       = in_data;
        hd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      hd_q       <= '0;
      hd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hd_q       <= hd_d;
      hd_valid_q <= hd_valid_d;
    end
  end

  assign bit_valid = (state_q == SHIFT);
  assign x_out     = bit_valid ? sh_bit : IDLE_LEVEL;
  assign word_done = bit_valid && (cnt == '0);
  assign busy      = bit_valid || hd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_bit_serializer : bench for seq_bit_serializer (W=4 and W=8)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_seq_bit_serializer;

  logic clk = 1'b0;
  logic clear;

  logic [3:0] in_data4;
  logic       in_valid4, in_ready4, x4, bv4, wd4, busy4;
  logic [7:0] in_data8;
  logic       in_valid8, in_ready8, x8, bv8, wd8, busy8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
    .clk(clk), .clear(clear), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .x_out(x4), .bit_valid(bv4), .word_done(wd4), .busy(busy4)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .clear(clear), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .x_out(x8), .bit_valid(bv8), .word_done(wd8), .busy(busy8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic x, input logic bv, input logic wd,
                        input logic rdy, input logic bsy);
    check({tag, ".x_out"},     x4,        x);
    check({tag, ".bit_valid"}, bv4,       bv);
    check({tag, ".word_done"}, wd4,       wd);
    check({tag, ".in_ready"},  in_ready4, rdy);
    check({tag, ".busy"},      busy4,     bsy);
  endtask

  // Reference model: bits still to appear on the line (front = current bit) plus a hold slot.
  bit       mq[$];
  bit [3:0] mhold;
  bit       mhold_full;

  task automatic m_load(input bit [3:0] w);
    mq.delete();
    for (int i = 3; i >= 0; i--) mq.push_back(w[i]);
  endtask

  task automatic m_step(input bit v, input bit [3:0] d);
    bit acc;
    acc = v && !mhold_full;
    if (mq.size() <= 1) begin
      if (mq.size() == 1) void'(mq.pop_front());
      if (mhold_full) begin
        m_load(mhold);
        mhold_full = 1'b0;
      end else if (acc) begin
        m_load(d);
        acc = 1'b0;
      end
    end else begin
      void'(mq.pop_front());
    end
    if (acc) begin
      mhold      = d;
      mhold_full = 1'b1;
    end
  endtask

  task automatic do_reset();
    #3 clear = 1'b1;
    in_valid4 = 1'b0; in_data4 = '0;
    in_valid8 = 1'b0; in_data8 = '0;
    tick();
    #2 clear = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       x, bv, wd, rdy, busy;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [3:0]  bp_words [3];
    logic [0:11] bp_bits;
    logic [0:11] bp_rdy;
    logic [0:7]  exp_lsb;
    int          idx;
    logic        pre_rdy, v;
    logic [3:0]  d;

    // Single word 1001, back-to-back 0011, 3-cycle idle gap, then 1010.
    tbl[0]  = '{1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    bp_words[0] = 4'h9; bp_words[1] = 4'h3; bp_words[2] = 4'hC;
    bp_bits = 12'b1001_0011_1100;
    bp_rdy  = 12'b1000_1000_1111;
    exp_lsb = 8'b1010_0101;

    clear = 1'b1;
    in_valid4 = 1'b0; in_data4 = '0;
    in_valid8 = 1'b0; in_data8 = '0;
    tick();
    check4("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 clear = 1'b0;
    tick();
    check4("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      in_valid4 = tbl[i].v;
      in_data4  = tbl[i].d;
      tick();
      check4($sformatf("tbl%0d", i), tbl[i].x, tbl[i].bv, tbl[i].wd, tbl[i].rdy, tbl[i].busy);
    end
    in_valid4 = 1'b0;

    // Backpressure: 9, 3, C offered with in_valid held high.
    idx = 0;
    for (int e = 0; e < 12; e++) begin
      in_valid4 = (idx < 3);
      in_data4  = (idx < 3) ? bp_words[idx] : 4'h0;
      pre_rdy   = in_ready4;
      tick();
      if (in_valid4 && pre_rdy) idx++;
      check($sformatf("bp_x%0d", e),   x4,        bp_bits[e]);
      check($sformatf("bp_bv%0d", e),  bv4,       1'b1);
      check($sformatf("bp_rdy%0d", e), in_ready4, bp_rdy[e]);
    end
    in_valid4 = 1'b0;
    tick();
    check4("bp_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB-first on the 8-bit instance.
    in_valid8 = 1'b1;
    in_data8  = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid8 = 1'b0;
      check($sformatf("lsb_x%0d", i),  x8,  exp_lsb[i]);
      check($sformatf("lsb_bv%0d", i), bv8, 1'b1);
      check($sformatf("lsb_wd%0d", i), wd8, (i == 7));
    end
    tick();
    check("lsb_idle_bv", bv8, 1'b0);
    check("lsb_idle_busy", busy8, 1'b0);
    check("lsb_idle_rdy", in_ready8, 1'b1);

    // Clear mid-word with a second word parked in hold.
    in_valid4 = 1'b1; in_data4 = 4'hB;
    tick();
    check("mid_x0", x4, 1'b1);
    in_data4 = 4'h6;
    tick();
    check("mid_x1", x4, 1'b0);
    check("mid_rdy", in_ready4, 1'b0);
    in_valid4 = 1'b0;
    #2 clear = 1'b1;
    #1;
    check4("async_clear", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    #2 clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check4($sformatf("after_clear%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // Randomized traffic against the queue model.
    do_reset();
    mq.delete();
    mhold_full = 1'b0;
    mhold = '0;
    v = 1'b0; d = '0;
    for (int c = 0; c < 400; c++) begin
      bit acc;
      if (!v) begin
        v = ($urandom_range(0, 3) != 0);
        d = 4'($urandom);
      end
      in_valid4 = v;
      in_data4  = d;
      acc = v && !mhold_full;
      m_step(v, d);
      tick();
      check4($sformatf("rnd%0d", c),
             (mq.size() > 0) ? mq[0] : 1'b0,
             mq.size() > 0, mq.size() == 1, !mhold_full,
             (mq.size() > 0) || mhold_full);
      if (acc) v = 1'b0;
    end
    in_valid4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
